// File: rtl/game_pkg.sv
// Shared constants for the falling-object game: command bytes, playfield
// limits and the receive FSM state encoding.
package game_pkg;

    localparam logic [7:0] CMD_LEFT   = 8'h4C;
    localparam logic [7:0] CMD_RIGHT  = 8'h52;
    localparam logic [7:0] CMD_CENTER = 8'h43;

    localparam int X_MIN  = 0;
    localparam int X_MAX  = 539;
    localparam int X_INIT = 270;
    localparam int PX_W   = 12;

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 serial byte receiver: 2-flop synchronizer, mid-bit sampling FSM,
// one-cycle valid / framing-error pulses on the stop-bit sample edge.
module uart_rx_byte #(
    parameter int DIV = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       ferr
);
    import game_pkg::*;

    localparam int            CW      = $clog2(DIV);
    localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(DIV - 1);

    logic [1:0]    sync_q;
    logic          prev_q;
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] div_q, div_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;
    logic          rxs;
    logic          fall;

    assign rxs  = sync_q[1];
    // Edge detect only: a line stuck low never re-arms the start search.
    assign fall = prev_q & ~rxs;

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (fall) begin
                    state_d = RX_START;
                    div_d   = '0;
                end
            end
            RX_START: begin
                if (div_q == HALF_M1) begin
                    div_d   = '0;
                    bit_d   = '0;
                    state_d = rxs ? RX_IDLE : RX_DATA;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (div_q == FULL_M1) begin
                    shift_d = {rxs, shift_q[7:1]};
                    div_d   = '0;
                    if (bit_q == 3'd7) state_d = RX_STOP;
                    else               bit_d   = bit_q + 3'd1;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (div_q == FULL_M1) begin
                    div_d   = '0;
                    state_d = RX_IDLE;
                    if (rxs) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q  <= 2'b11;
            prev_q  <= 1'b1;
            state_q <= RX_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], rx};
            prev_q  <= rxs;
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    assign data  = data_q;
    assign valid = valid_q;
    assign ferr  = ferr_q;

endmodule

// File: rtl/bt_player_ctrl.sv
// Bluetooth player-position controller: decodes L/R/C command bytes from the
// serial receiver and keeps the clamped player x position.
module bt_player_ctrl #(
    parameter int CLK_HZ = 100_000_000,
    parameter int BAUD   = 9600,
    parameter int X_MIN  = game_pkg::X_MIN,
    parameter int X_MAX  = game_pkg::X_MAX,
    parameter int STEP   = 8,
    parameter int X_INIT = game_pkg::X_INIT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    input  logic        ena,
    output logic [11:0] p_x,
    output logic [7:0]  cmd,
    output logic        cmd_valid,
    output logic        frame_err
);
    import game_pkg::*;

    localparam int DIV = CLK_HZ / BAUD;

    localparam logic [PX_W-1:0] XMIN_C   = PX_W'(X_MIN);
    localparam logic [PX_W-1:0] XMAX_C   = PX_W'(X_MAX);
    localparam logic [PX_W-1:0] XINIT_C  = PX_W'(X_INIT);
    localparam logic [PX_W-1:0] STEP_C   = PX_W'(STEP);
    // Thresholds folded into constants so neither move can wrap around.
    localparam logic [PX_W-1:0] LEFT_TH  = PX_W'(X_MIN + STEP);
    localparam logic [PX_W-1:0] RIGHT_TH = PX_W'(X_MAX - STEP);

    logic [PX_W-1:0] px_q, px_d;

    uart_rx_byte #(
        .DIV (DIV)
    ) u_rx (
        .clk   (clk),
        .rst   (rst),
        .rx    (rx),
        .data  (cmd),
        .valid (cmd_valid),
        .ferr  (frame_err)
    );

    always_comb begin
        px_d = px_q;
        if (cmd_valid && ena) begin
            case (cmd)
                CMD_LEFT:   px_d = (px_q < LEFT_TH)  ? XMIN_C : px_q - STEP_C;
                CMD_RIGHT:  px_d = (px_q > RIGHT_TH) ? XMAX_C : px_q + STEP_C;
                CMD_CENTER: px_d = XINIT_C;
                default:    px_d = px_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) px_q <= XINIT_C;
        else      px_q <= px_d;
    end

    assign p_x = px_q;

endmodule

// File: tb/tb_bt_player_ctrl.sv
// Bench for bt_player_ctrl at DIV = 10: directed scenarios plus randomized
// command streams checked against a saturating-arithmetic position model.
module tb_bt_player_ctrl;

    localparam int DIV = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rx  = 1'b1;
    logic        ena_tb = 1'b1;
    logic        ena_kill = 1'b0;
    logic        drop_req = 1'b0;
    logic        ena;
    logic [11:0] p_x;
    logic [7:0]  cmd;
    logic        cmd_valid;
    logic        frame_err;

    int          n_vec = 0;
    int          n_err = 0;
    int          cnt_v = 0;
    int          cnt_f = 0;
    int          cnt_both = 0;
    logic [11:0] px_at = '0;
    logic [11:0] px_next = '0;
    bit          v_prev = 1'b0;

    logic [11:0] model_px = 12'd270;
    logic [7:0]  exp_cmd  = 8'h00;

    assign ena = ena_tb & ~ena_kill;

    always #5 clk = ~clk;

    bt_player_ctrl #(
        .CLK_HZ (1_000_000),
        .BAUD   (100_000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .ena       (ena),
        .p_x       (p_x),
        .cmd       (cmd),
        .cmd_valid (cmd_valid),
        .frame_err (frame_err)
    );

    // Pulse recorder: counts pulses, snapshots p_x in the pulse cycle and
    // the cycle after, and optionally drops ena right after a valid pulse.
    always @(negedge clk) begin
        if (v_prev) px_next = p_x;
        if (cmd_valid) begin
            cnt_v++;
            px_at = p_x;
        end
        if (frame_err) cnt_f++;
        if (cmd_valid && frame_err) cnt_both++;
        if (!drop_req)      ena_kill = 1'b0;
        else if (cmd_valid) ena_kill = 1'b1;
        v_prev = cmd_valid;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [11:0] mdl(input logic [11:0] px, input logic [7:0] b, input bit en);
        int x;
        x = int'(px);
        if (en) begin
            case (b)
                8'h4C:   x = (x - 8 < 0) ? 0 : x - 8;
                8'h52:   x = (x + 8 > 539) ? 539 : x + 8;
                8'h43:   x = 270;
                default: x = x;
            endcase
        end
        return 12'(x);
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives one 8N1 frame and advances the reference model.
    task automatic tx_byte(input logic [7:0] b, input bit stop_ok, input int idle_bits);
        if (stop_ok) begin
            model_px = mdl(model_px, b, ena_tb && !drop_req);
            exp_cmd  = b;
        end
        rx = 1'b0;
        wait_cyc(DIV);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_cyc(DIV);
        end
        rx = stop_ok;
        wait_cyc(DIV);
        if (!stop_ok) begin
            rx = 1'b1;
            wait_cyc(DIV);
        end
        rx = 1'b1;
        wait_cyc(DIV * idle_bits);
    endtask

    task automatic test_reset;
        rst = 1'b0;
        wait_cyc(3);
        n_vec++; if (p_x !== 12'd270) begin n_err++; $display("FAIL rst_px: got %0d want 270", p_x); end
        n_vec++; if (cmd !== 8'h00) begin n_err++; $display("FAIL rst_cmd: got %h want 00", cmd); end
        n_vec++; if (cmd_valid !== 1'b0 || frame_err !== 1'b0) begin
            n_err++; $display("FAIL rst_pulse: got v=%b f=%b want 0 0", cmd_valid, frame_err);
        end
        rst = 1'b1;
        wait_cyc(5);
    endtask

    task automatic test_right_left;
        int cv0;
        ena_tb = 1'b1;
        cv0 = cnt_v;
        tx_byte(8'h52, 1'b1, 1);
        n_vec++; if (cnt_v - cv0 != 1) begin n_err++; $display("FAIL r_pulses: got %0d want 1", cnt_v - cv0); end
        n_vec++; if (px_at !== 12'd270) begin n_err++; $display("FAIL r_px_at_pulse: got %0d want 270", px_at); end
        n_vec++; if (px_next !== 12'd278) begin n_err++; $display("FAIL r_px_next: got %0d want 278", px_next); end
        n_vec++; if (cmd !== 8'h52) begin n_err++; $display("FAIL r_cmd: got %h want 52", cmd); end
        cv0 = cnt_v;
        tx_byte(8'h4C, 1'b1, 1);
        n_vec++; if (cnt_v - cv0 != 1) begin n_err++; $display("FAIL l_pulses: got %0d want 1", cnt_v - cv0); end
        n_vec++; if (px_at !== 12'd278) begin n_err++; $display("FAIL l_px_at_pulse: got %0d want 278", px_at); end
        n_vec++; if (p_x !== 12'd270 || p_x !== model_px) begin
            n_err++; $display("FAIL l_px: got %0d want 270", p_x);
        end
    endtask

    task automatic test_clamp;
        tx_byte(8'h43, 1'b1, 0);
        repeat (33) tx_byte(8'h4C, 1'b1, 0);
        n_vec++; if (p_x !== 12'd6) begin n_err++; $display("FAIL ramp_low: got %0d want 6", p_x); end
        tx_byte(8'h4C, 1'b1, 0);
        n_vec++; if (p_x !== 12'd0) begin n_err++; $display("FAIL clamp_min: got %0d want 0", p_x); end
        tx_byte(8'h4C, 1'b1, 0);
        n_vec++; if (p_x !== 12'd0) begin n_err++; $display("FAIL hold_min: got %0d want 0", p_x); end
        tx_byte(8'h43, 1'b1, 0);
        repeat (33) tx_byte(8'h52, 1'b1, 0);
        n_vec++; if (p_x !== 12'd534) begin n_err++; $display("FAIL ramp_high: got %0d want 534", p_x); end
        tx_byte(8'h52, 1'b1, 0);
        n_vec++; if (p_x !== 12'd539) begin n_err++; $display("FAIL clamp_max: got %0d want 539", p_x); end
        tx_byte(8'h52, 1'b1, 0);
        n_vec++; if (p_x !== 12'd539) begin n_err++; $display("FAIL hold_max: got %0d want 539", p_x); end
        tx_byte(8'h4C, 1'b1, 0);
        tx_byte(8'h52, 1'b1, 1);
        n_vec++; if (p_x !== 12'd539 || p_x !== model_px) begin
            n_err++; $display("FAIL edge_531: got %0d want 539", p_x);
        end
    endtask

    task automatic test_framing;
        int cv0, cf0;
        logic [11:0] px0;
        logic [7:0]  c0;
        cv0 = cnt_v; cf0 = cnt_f; px0 = p_x; c0 = cmd;
        tx_byte(8'h52, 1'b0, 1);
        n_vec++; if (cnt_f - cf0 != 1) begin n_err++; $display("FAIL fe_pulses: got %0d want 1", cnt_f - cf0); end
        n_vec++; if (cnt_v - cv0 != 0) begin n_err++; $display("FAIL fe_valid: got %0d want 0", cnt_v - cv0); end
        n_vec++; if (cmd !== exp_cmd || cmd !== c0) begin n_err++; $display("FAIL fe_cmd: got %h want %h", cmd, exp_cmd); end
        n_vec++; if (p_x !== model_px || p_x !== px0) begin n_err++; $display("FAIL fe_px: got %0d want %0d", p_x, model_px); end
        tx_byte(8'h43, 1'b1, 1);
        n_vec++; if (p_x !== 12'd270 || cmd !== 8'h43) begin
            n_err++; $display("FAIL fe_recover: got px=%0d cmd=%h want px=270 cmd=43", p_x, cmd);
        end
        cv0 = cnt_v; cf0 = cnt_f;
        rx = 1'b0;
        wait_cyc(3);
        rx = 1'b1;
        wait_cyc(3 * DIV);
        n_vec++; if (cnt_v != cv0 || cnt_f != cf0) begin
            n_err++; $display("FAIL glitch: got v=%0d f=%0d pulses want 0 0", cnt_v - cv0, cnt_f - cf0);
        end
    endtask

    task automatic test_disabled;
        int cv0;
        tx_byte(8'h52, 1'b1, 1);
        ena_tb = 1'b0;
        wait_cyc(2);
        cv0 = cnt_v;
        tx_byte(8'h52, 1'b1, 1);
        tx_byte(8'h4C, 1'b1, 1);
        n_vec++; if (cnt_v - cv0 != 2) begin n_err++; $display("FAIL dis_pulses: got %0d want 2", cnt_v - cv0); end
        n_vec++; if (cmd !== 8'h4C) begin n_err++; $display("FAIL dis_cmd: got %h want 4c", cmd); end
        n_vec++; if (p_x !== 12'd278 || p_x !== model_px) begin n_err++; $display("FAIL dis_px: got %0d want 278", p_x); end
        ena_tb = 1'b1;
        tx_byte(8'h43, 1'b1, 1);
        n_vec++; if (p_x !== 12'd270) begin n_err++; $display("FAIL en_center: got %0d want 270", p_x); end
        drop_req = 1'b1;
        tx_byte(8'h52, 1'b1, 1);
        n_vec++; if (p_x !== 12'd270 || p_x !== model_px) begin n_err++; $display("FAIL ena_fall: got %0d want 270", p_x); end
        drop_req = 1'b0;
        wait_cyc(20);
        n_vec++; if (p_x !== 12'd270) begin n_err++; $display("FAIL ena_replay: got %0d want 270", p_x); end
    endtask

    task automatic test_back_to_back;
        int cv0;
        tx_byte(8'h43, 1'b1, 1);
        cv0 = cnt_v;
        repeat (16) tx_byte(8'h52, 1'b1, 0);
        wait_cyc(DIV);
        n_vec++; if (cnt_v - cv0 != 16) begin n_err++; $display("FAIL b2b_pulses: got %0d want 16", cnt_v - cv0); end
        n_vec++; if (p_x !== 12'd398 || p_x !== model_px) begin n_err++; $display("FAIL b2b_px: got %0d want 398", p_x); end
        cv0 = cnt_v;
        tx_byte(8'h41, 1'b1, 1);
        n_vec++; if (cnt_v - cv0 != 1 || cmd !== 8'h41) begin
            n_err++; $display("FAIL unk_cmd: got pulses=%0d cmd=%h want 1 41", cnt_v - cv0, cmd);
        end
        n_vec++; if (p_x !== 12'd398) begin n_err++; $display("FAIL unk_px: got %0d want 398", p_x); end
    endtask

    task automatic test_random;
        int cv0, cf0, r, idle;
        bit ok;
        logic [7:0] b;
        for (int i = 0; i < 30; i++) begin
            r = $urandom_range(0, 3);
            b = (r == 0) ? 8'h4C : (r == 1) ? 8'h52 : (r == 2) ? 8'h43 : 8'($urandom);
            ena_tb = ($urandom_range(0, 3) != 0);
            ok     = ($urandom_range(0, 7) != 0);
            idle   = $urandom_range(0, 2);
            cv0 = cnt_v; cf0 = cnt_f;
            tx_byte(b, ok, idle);
            n_vec++; if (cnt_v - cv0 != int'(ok) || cnt_f - cf0 != int'(!ok)) begin
                n_err++; $display("FAIL rnd_pulse[%0d]: got v=%0d f=%0d want ok=%0d", i, cnt_v - cv0, cnt_f - cf0, ok);
            end
            n_vec++; if (p_x !== model_px || cmd !== exp_cmd) begin
                n_err++; $display("FAIL rnd_state[%0d]: got px=%0d cmd=%h want px=%0d cmd=%h", i, p_x, cmd, model_px, exp_cmd);
            end
        end
        ena_tb = 1'b1;
    endtask

    task automatic test_reset_mid;
        int cv0, cf0;
        tx_byte(8'h43, 1'b1, 0);
        tx_byte(8'h52, 1'b1, 1);
        cv0 = cnt_v; cf0 = cnt_f;
        rx = 1'b0;
        wait_cyc(DIV + 4);
        rx = 1'b1;
        wait_cyc(DIV);
        rx = 1'b0;
        wait_cyc(2 * DIV);
        rst = 1'b0;
        rx  = 1'b1;
        wait_cyc(2);
        model_px = 12'd270;
        exp_cmd  = 8'h00;
        n_vec++; if (p_x !== 12'd270 || cmd !== 8'h00) begin
            n_err++; $display("FAIL mid_rst: got px=%0d cmd=%h want 270 00", p_x, cmd);
        end
        rst = 1'b1;
        wait_cyc(15 * DIV);
        n_vec++; if (cnt_v != cv0 || cnt_f != cf0) begin
            n_err++; $display("FAIL mid_rst_pulse: got v=%0d f=%0d want 0 0", cnt_v - cv0, cnt_f - cf0);
        end
        n_vec++; if (p_x !== 12'd270 || cmd !== 8'h00) begin
            n_err++; $display("FAIL mid_rst_after: got px=%0d cmd=%h want 270 00", p_x, cmd);
        end
        tx_byte(8'h4C, 1'b1, 1);
        n_vec++; if (p_x !== model_px || p_x !== 12'd262) begin
            n_err++; $display("FAIL post_rst_rx: got %0d want 262", p_x);
        end
    endtask

    initial begin
        test_reset();
        test_right_left();
        test_clamp();
        test_framing();
        test_disabled();
        test_back_to_back();
        test_random();
        test_reset_mid();
        n_vec++; if (cnt_both != 0) begin n_err++; $display("FAIL exclusive: got %0d overlaps want 0", cnt_both); end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
